// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: column drive, 2-flop row sync, per-frame one-hot decode, frame-level debounce.
// Latency (DEBOUNCE_CNT-1)*F .. (DEBOUNCE_CNT+1)*F+4 cycles (F = 3*SCAN_DIV); no backpressure, key_pulse is a bare strobe.
module keypad_scanner #(
    parameter int         SCAN_DIV     = 4,
    parameter int         DEBOUNCE_CNT = 3,
    parameter logic [3:0] NOKEY        = 4'd10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [2:0] col,
    output logic [3:0] key,
    output logic       key_pulse
);

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2
    } col_state_e;

    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
    localparam logic [3:0] CNT_MAX  = 4'(DEBOUNCE_CNT);

    logic [3:0]  row_meta_q, row_meta_d;
    logic [3:0]  row_s_q, row_s_d;
    logic [7:0]  div_q, div_d;
    col_state_e  state_q, state_d;
    logic [11:0] frame_q, frame_d;
    logic [3:0]  frame_code_q, frame_code_d;
    logic        frame_vld_q, frame_vld_d;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  key_q, key_d;
    logic        pulse_q, pulse_d;
    logic        slot_last;
    logic [2:0]  col_drv;

    // Frame bit c*4+r holds row r of column c; anything not exactly one digit is NOKEY.
    function automatic logic [3:0] decode_frame(input logic [11:0] f);
        logic [3:0] code;
        case (f)
            12'h001: code = 4'd1;
            12'h002: code = 4'd4;
            12'h004: code = 4'd7;
            12'h010: code = 4'd2;
            12'h020: code = 4'd5;
            12'h040: code = 4'd8;
            12'h080: code = 4'd0;
            12'h100: code = 4'd3;
            12'h200: code = 4'd6;
            12'h400: code = 4'd9;
            default: code = NOKEY;
        endcase
        return code;
    endfunction

    always_comb begin
        row_meta_d   = row;
        row_s_d      = row_meta_q;
        slot_last    = (div_q == DIV_LAST);
        div_d        = slot_last ? 8'd0 : div_q + 8'd1;
        state_d      = state_q;
        frame_d      = frame_q;
        frame_code_d = frame_code_q;
        frame_vld_d  = 1'b0;
        col_drv      = 3'b110;

        case (state_q)
            COL0: begin
                col_drv = 3'b110;
                if (slot_last) begin
                    frame_d[3:0] = ~row_s_q;
                    state_d      = COL1;
                end
            end
            COL1: begin
                col_drv = 3'b101;
                if (slot_last) begin
                    frame_d[7:4] = ~row_s_q;
                    state_d      = COL2;
                end
            end
            COL2: begin
                col_drv = 3'b011;
                if (slot_last) begin
                    frame_d[11:8] = ~row_s_q;
                    state_d       = COL0;
                    // Decode includes the column-2 sample landing on this same edge.
                    frame_code_d  = decode_frame(frame_d);
                    frame_vld_d   = 1'b1;
                end
            end
            default: begin
                col_drv = 3'b110;
                state_d = COL0;
            end
        endcase

        cand_d  = cand_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        pulse_d = 1'b0;
        if (frame_vld_q) begin
            if (frame_code_q == cand_q) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                cand_d = frame_code_q;
                cnt_d  = 4'd1;
            end
            if ((cnt_d == CNT_MAX) && (cand_d != key_q)) begin
                key_d   = cand_d;
                pulse_d = (cand_d != NOKEY);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_meta_q   <= 4'b1111;
            row_s_q      <= 4'b1111;
            div_q        <= 8'd0;
            state_q      <= COL0;
            frame_q      <= 12'h000;
            frame_code_q <= NOKEY;
            frame_vld_q  <= 1'b0;
            cand_q       <= NOKEY;
            cnt_q        <= 4'd0;
            key_q        <= NOKEY;
            pulse_q      <= 1'b0;
        end else begin
            row_meta_q   <= row_meta_d;
            row_s_q      <= row_s_d;
            div_q        <= div_d;
            state_q      <= state_d;
            frame_q      <= frame_d;
            frame_code_q <= frame_code_d;
            frame_vld_q  <= frame_vld_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            pulse_q      <= pulse_d;
        end
    end

    assign col       = col_drv;
    assign key       = key_q;
    assign key_pulse = pulse_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model closes the row/col loop; key events are checked against a queue.
module tb_keypad_scanner;

    logic        clock;
    logic        reset;
    logic [3:0]  row;
    logic [2:0]  col;
    logic [3:0]  key;
    logic        key_pulse;
    logic [11:0] pressed;

    typedef struct {
        logic [3:0] key;
        logic       pulse;
    } exp_t;

    exp_t       exp_q[$];
    int         checks    = 0;
    int         failures  = 0;
    int         cyc       = 0;
    int         ev_cycle  = 0;
    int         pulse_cnt = 0;
    logic [3:0] last_key  = 4'd10;

    localparam logic [11:0] STAR = 12'h008;
    localparam logic [11:0] HASH = 12'h800;

    keypad_scanner #(
        .SCAN_DIV    (4),
        .DEBOUNCE_CNT(3),
        .NOKEY       (4'd10)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .key      (key),
        .key_pulse(key_pulse)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    // Keypad: a pressed switch at (row r, column c) pulls row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (pressed[c*4+r] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    function automatic logic [11:0] digit_mask(input int d);
        case (d)
            1: return 12'h001;
            4: return 12'h002;
            7: return 12'h004;
            2: return 12'h010;
            5: return 12'h020;
            8: return 12'h040;
            0: return 12'h080;
            3: return 12'h100;
            6: return 12'h200;
            9: return 12'h400;
            default: return 12'h000;
        endcase
    endfunction

    // Monitor: every change on key must match the head of the expected queue.
    always @(negedge clock) begin
        exp_t e;
        if (key !== last_key) begin
            ev_cycle = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_key_event got key=%0d pulse=%0b expected no change", key, key_pulse);
            end else begin
                e = exp_q.pop_front();
                if (key !== e.key || key_pulse !== e.pulse) begin
                    failures++;
                    $display("FAIL key_event got key=%0d pulse=%0b expected key=%0d pulse=%0b",
                             key, key_pulse, e.key, e.pulse);
                end
            end
            last_key = key;
        end else if (key_pulse !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL spurious_pulse got key_pulse=%0b with key=%0d unchanged expected 0", key_pulse, key);
        end
        if (key_pulse === 1'b1) pulse_cnt++;
    end

    task automatic check(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, want);
        end
    endtask

    task automatic push(input logic [3:0] k, input logic p);
        exp_t e;
        e.key   = k;
        e.pulse = p;
        exp_q.push_back(e);
    endtask

    // Wait for the queue to drain, then check the event landed inside the latency window.
    task automatic wait_event(input string nm, input int t0, input bit chk_lo);
        int n;
        int el;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clock);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout got no key event in %0d cycles expected one within 52", nm, n);
            exp_q.delete();
        end else begin
            el = ev_cycle - t0;
            checks++;
            if (el > 52 || (chk_lo && el < 24)) begin
                failures++;
                $display("FAIL %s_latency got=%0d cycles expected 24..52", nm, el);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    initial begin
        int p0;
        int t0;
        logic [11:0] bad [3];
        bad[0] = 12'h001 | 12'h400;
        bad[1] = STAR;
        bad[2] = HASH;

        pressed = 12'h000;
        reset   = 1'b1;
        #2 reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            #1;
            check("reset_col", int'(col), 6);
            check("reset_key", int'(key), 10);
            check("reset_pulse", int'(key_pulse), 0);
        end
        reset = 1'b1;
        for (int i = 0; i < 24; i++) begin
            int want;
            case ((i / 4) % 3)
                0: want = 6;
                1: want = 5;
                default: want = 3;
            endcase
            check("col_sequence", int'(col), want);
            @(negedge clock);
            #1;
        end
        idle(40);

        // Clean digit 5 held ~200 cycles, then released.
        p0 = pulse_cnt;
        pressed = digit_mask(5);
        t0 = cyc;
        push(4'd5, 1'b1);
        wait_event("press5", t0, 1'b1);
        idle(160);
        check("key_held5", int'(key), 5);
        pressed = 12'h000;
        t0 = cyc;
        push(4'd10, 1'b0);
        wait_event("release5", t0, 1'b1);
        check("pulses5", pulse_cnt - p0, 1);

        // Digit 8 bouncing every 5 cycles, then stable.
        p0 = pulse_cnt;
        push(4'd8, 1'b1);
        for (int i = 0; i < 4; i++) begin
            pressed = (i % 2 == 0) ? digit_mask(8) : 12'h000;
            idle(5);
        end
        pressed = digit_mask(8);
        t0 = cyc;
        wait_event("bounce8", t0, 1'b0);
        idle(60);
        pressed = 12'h000;
        t0 = cyc;
        push(4'd10, 1'b0);
        wait_event("release8", t0, 1'b1);
        check("pulses8", pulse_cnt - p0, 1);

        // Ghost (1+9), star and hash must all leave key at NOKEY.
        for (int i = 0; i < 3; i++) begin
            p0 = pulse_cnt;
            pressed = bad[i];
            idle(100);
            check("invalid_key", int'(key), 10);
            check("invalid_pulses", pulse_cnt - p0, 0);
            pressed = 12'h000;
            idle(60);
        end

        // Roll-over 0 -> 3 without a gap.
        p0 = pulse_cnt;
        pressed = digit_mask(0);
        t0 = cyc;
        push(4'd0, 1'b1);
        wait_event("press0", t0, 1'b1);
        idle(50);
        pressed = digit_mask(3);
        t0 = cyc;
        push(4'd3, 1'b1);
        wait_event("roll3", t0, 1'b1);
        idle(30);
        pressed = 12'h000;
        t0 = cyc;
        push(4'd10, 1'b0);
        wait_event("release3", t0, 1'b1);
        check("pulses_roll", pulse_cnt - p0, 2);

        // Reset pulsed while 7 is held: re-acquired with a fresh pulse.
        p0 = pulse_cnt;
        pressed = digit_mask(7);
        t0 = cyc;
        push(4'd7, 1'b1);
        wait_event("press7", t0, 1'b1);
        idle(20);
        push(4'd10, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            check("midreset_key", int'(key), 10);
            check("midreset_col", int'(col), 6);
            check("midreset_pulse", int'(key_pulse), 0);
        end
        check("midreset_queue", exp_q.size(), 0);
        reset = 1'b1;
        t0 = cyc;
        push(4'd7, 1'b1);
        wait_event("reacquire7", t0, 1'b1);
        check("pulses7", pulse_cnt - p0, 2);
        idle(20);
        pressed = 12'h000;
        t0 = cyc;
        push(4'd10, 1'b0);
        wait_event("release7", t0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Front-end for the alarm clock controller.
- Scans a 4x3 matrix keypad, synchronises and debounces the row returns, and decodes one digit press.
- Drives the 4-bit `key` bus into the controller FSM: digits 0-9 while a key is held, 10 (no key) otherwise.
- Also emits a one-cycle strobe per accepted digit for the key-shift register.

Parameters:
- SCAN_DIV, 4, clock cycles each column is driven; legal range 3..255.
- DEBOUNCE_CNT, 3, consecutive identical frames needed to accept a change; legal range 2..15.
- NOKEY, 10, code output when no valid digit is held.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- row  input  4  keypad row returns, active-low (pulled up), asynchronous to clock
- col  output  3  column drive, active-low one-hot
- key  output  4  debounced key code, 0-9 or NOKEY; level held while the key is held
- key_pulse  output  1  one-cycle strobe when `key` changes to a digit

Behaviour:
- Reset (reset=0, asynchronous), all values forced:
  - col=3'b110; key=NOKEY; key_pulse=0.
  - Divider=0; column state COL0; synchroniser flops=4'b1111.
  - Frame accumulator cleared; candidate=NOKEY; stable_cnt=0.
- Synchroniser: `row` passes through 2 flops (row_s) before any use.
- Column FSM:
  - States COL0 -> COL1 -> COL2 -> COL0, each lasting exactly SCAN_DIV cycles.
  - col is 110 / 101 / 011 in COL0 / COL1 / COL2.
  - No other pattern is ever driven, including the cycle after reset release.
- Sampling:
  - On the last cycle of each slot (divider==SCAN_DIV-1), row_s is inverted and stored into that column's 4-bit slot of the frame accumulator.
  - SCAN_DIV>=3 guarantees row_s reflects the current column.
- Frame decode happens on the edge ending COL2, into registered frame_code:
  - Exactly one bit set across the 12 bits, mapped as follows:
    - row0: 1,2,3
    - row1: 4,5,6
    - row2: 7,8,9
    - row3: *,0,#
  - `*` or `#` -> NOKEY.
  - Zero bits or more than one bit set -> NOKEY (ghost reject).
- Debounce, evaluated the cycle after frame_code is registered:
  - If frame_code==candidate: stable_cnt increments, saturating at DEBOUNCE_CNT.
  - Else: candidate<=frame_code and stable_cnt<=1.
  - Accept condition: stable_cnt (new value) == DEBOUNCE_CNT and candidate != key. Then key<=candidate on that edge.
  - key_pulse=1 for exactly that one cycle if the new key != NOKEY.
- Digit-to-digit change without an intervening NOKEY is accepted normally and produces a pulse.
- A held key produces exactly one pulse, regardless of duration.
- Latency, frame F = 3*SCAN_DIV cycles:
  - A clean, stable press is reflected on `key` no later than (DEBOUNCE_CNT+1)*F+4 cycles after `row` settles.
  - It is reflected no earlier than (DEBOUNCE_CNT-1)*F cycles after.
  - Release to NOKEY follows the same bounds.
- Glitches: any disturbance shorter than (DEBOUNCE_CNT-1)*F cycles never changes `key`.
- Reset asserted mid-press: outputs return to reset values immediately. After release, the held key is re-acquired under full debounce and produces a new pulse.

Test Plan:
- Reset:
  - Hold reset=0 for 5 cycles, row=4'hF.
  - Required: col=110, key=10, key_pulse=0 throughout.
  - After release: col sequence 110 x4, 101 x4, 011 x4, repeating.
- Digit 5 (row1 pulled low only while col=101), held 200 cycles:
  - key=5 within 52 cycles; exactly one key_pulse.
  - After release, key=10 within 52 cycles; no pulse.
- Bounce:
  - Digit 8 toggling every 5 cycles for 20 cycles, then stable.
  - Required: key never shows an intermediate value, goes 10 -> 8 once, one pulse.
- Ghost / invalid:
  - Digits 1 and 9 pressed simultaneously -> key stays 10, no pulse.
  - `*` alone -> key stays 10.
  - `#` alone -> key stays 10.
- Roll-over:
  - Digit 0 held, then switched directly to digit 3 without a gap.
  - Required: key goes 0 -> 3; two pulses total.
- Reset mid-press:
  - Digit 7 accepted, then reset pulsed low 3 cycles while 7 is still held.
  - Required: key=10 during reset, then 7 again within 52 cycles, with a second pulse.
